xadc_drp_sequencer: RTL

- Controls the DRP port of the dual 12-bit XADC primitive.
- On each end-of-conversion pulse, reads the converted channel's status register and presents the 12-bit result.
- Also arbitrates a host read/write requester onto the same DRP so configuration and auto-readback share one port.
- Sits between the XADC instance and the system register/control logic, in the DCLK domain.

---
 rtl/xadc_drp_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer
// Shares the XADC DRP port between automatic end-of-conversion readback and
// a host read/write requester. Every output is registered.
//   DCLK/RESET_N       : DRP clock, asynchronous active-low reset
//   EOC/CHANNEL        : conversion done strobe and its channel
//   XADC_*             : DRP master signals toward the XADC primitive
//   HOST_*             : host request (held until HOST_ACK) and response
//   RESULT_*           : auto-readback result, RESULT_VALID one-cycle pulse
//   OVERRUN/TIMEOUT    : sticky error flags, cleared by CLEAR_FLAGS
// Optional build macro XADC_CHAN_MASK_EN adds CHANNEL_MASK[31:0]; an EOC
// whose channel bit is 0 is then ignored entirely.
module xadc_drp_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 7
) (
  input  logic              DCLK,
  input  logic              RESET_N,
  input  logic              EOC,
  input  logic [4:0]        CHANNEL,
  input  logic              XADC_DRDY,
  input  logic [15:0]       XADC_DO,
  output logic              XADC_DEN,
  output logic              XADC_DWE,
  output logic [ADDR_W-1:0] XADC_DADDR,
  output logic [15:0]       XADC_DI,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [15:0]       HOST_WDATA,
  output logic              HOST_ACK,
  output logic [15:0]       HOST_RDATA,
  output logic              RESULT_VALID,
  output logic [4:0]        RESULT_CHANNEL,
  output logic [11:0]       RESULT_DATA,
  output logic              OVERRUN,
  output logic              TIMEOUT,
  input  logic              CLEAR_FLAGS
`ifdef XADC_CHAN_MASK_EN
  ,
  input  logic [31:0]       CHANNEL_MASK
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_H, WAIT_A, WAIT_H} state_t;

  state_t            state_q, state_d;
  logic [9:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [4:0]        pch_q, pch_d;     // pending channel
  logic [4:0]        ach_q, ach_d;     // channel of the auto read in flight
  logic              last_auto_q, last_auto_d;
  logic              hwe_q, hwe_d;
  logic              den_q, den_d, dwe_q, dwe_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [15:0]       di_q, di_d;
  logic              ack_q, ack_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              rv_q, rv_d;
  logic [4:0]        rch_q, rch_d;
  logic [11:0]       rdat_q, rdat_d;
  logic              ovr_q, ovr_d, to_q, to_d;
  logic              eoc_v, consume, ovr_set, to_set, host_ok, auto_ok;
  logic [4:0]        chan_sel;

`ifdef XADC_CHAN_MASK_EN
  assign eoc_v = EOC & CHANNEL_MASK[CHANNEL];
`else
  assign eoc_v = EOC;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pend_d      = pend_q;
    pch_d       = pch_q;
    ach_d       = ach_q;
    last_auto_d = last_auto_q;
    hwe_d       = hwe_q;
    den_d       = 1'b0;
    dwe_d       = 1'b0;
    daddr_d     = '0;
    di_d        = '0;
    ack_d       = 1'b0;
    rdata_d     = '0;
    rv_d        = 1'b0;
    rch_d       = rch_q;
    rdat_d      = rdat_q;
    consume     = 1'b0;
    ovr_set     = 1'b0;
    to_set      = 1'b0;
    chan_sel    = pend_q ? pch_q : CHANNEL;
    // HOST_REQ is still high in the cycle its ACK is visible; don't re-serve it.
    host_ok     = HOST_REQ & ~ack_q;
    auto_ok     = pend_q | eoc_v;
    case (state_q)
      IDLE: begin
        // Auto wins unless the previous transaction was also auto.
        if (auto_ok && !(last_auto_q && host_ok)) begin
          state_d = ISSUE_A;
          consume = 1'b1;
          ach_d   = chan_sel;
          den_d   = 1'b1;
          daddr_d = ADDR_W'(chan_sel);
        end else if (host_ok) begin
          state_d = ISSUE_H;
          hwe_d   = HOST_WE;
          den_d   = 1'b1;
          dwe_d   = HOST_WE;
          daddr_d = HOST_ADDR;
          di_d    = HOST_WDATA;
        end
      end
      ISSUE_A: state_d = WAIT_A;
      ISSUE_H: state_d = WAIT_H;
      WAIT_A: begin
        if (XADC_DRDY) begin
          state_d     = IDLE;
          last_auto_d = 1'b1;
          rv_d        = 1'b1;
          rdat_d      = XADC_DO[15:4];
          rch_d       = ach_q;
        end else if (cnt_q == 10'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          last_auto_d = 1'b1;
          to_set      = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      WAIT_H: begin
        if (XADC_DRDY) begin
          state_d     = IDLE;
          last_auto_d = 1'b0;
          ack_d       = 1'b1;
          rdata_d     = hwe_q ? 16'h0 : XADC_DO;
        end else if (cnt_q == 10'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          last_auto_d = 1'b0;
          ack_d       = 1'b1;
          to_set      = 1'b1;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pending slot: an EOC not serviced directly this cycle is parked here.
    if (consume) pend_d = 1'b0;
    if (eoc_v && !(consume && !pend_q)) begin
      if (pend_q && !consume) ovr_set = 1'b1;
      pend_d = 1'b1;
      pch_d  = CHANNEL;
    end

    ovr_d = ovr_set | (ovr_q & ~CLEAR_FLAGS);
    to_d  = to_set  | (to_q  & ~CLEAR_FLAGS);
  end

  always_ff @(posedge DCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pch_q       <= '0;
      ach_q       <= '0;
      last_auto_q <= 1'b0;
      hwe_q       <= 1'b0;
      den_q       <= 1'b0;
      dwe_q       <= 1'b0;
      daddr_q     <= '0;
      di_q        <= '0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      rv_q        <= 1'b0;
      rch_q       <= '0;
      rdat_q      <= '0;
      ovr_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pch_q       <= pch_d;
      ach_q       <= ach_d;
      last_auto_q <= last_auto_d;
      hwe_q       <= hwe_d;
      den_q       <= den_d;
      dwe_q       <= dwe_d;
      daddr_q     <= daddr_d;
      di_q        <= di_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      rv_q        <= rv_d;
      rch_q       <= rch_d;
      rdat_q      <= rdat_d;
      ovr_q       <= ovr_d;
      to_q        <= to_d;
    end
  end

  assign XADC_DEN       = den_q;
  assign XADC_DWE       = dwe_q;
  assign XADC_DADDR     = daddr_q;
  assign XADC_DI        = di_q;
  assign HOST_ACK       = ack_q;
  assign HOST_RDATA     = rdata_q;
  assign RESULT_VALID   = rv_q;
  assign RESULT_CHANNEL = rch_q;
  assign RESULT_DATA    = rdat_q;
  assign OVERRUN        = ovr_q;
  assign TIMEOUT        = to_q;

endmodule
